// File: rtl/bf_mem_responder_pkg.sv
// Shared definitions for the brainf*ck memory responder.
// Holds the responder state encoding, default memory depths and the
// program-counter width seen on the processor bus.
package bf_mem_responder_pkg;

  localparam int unsigned DefTapeDepth = 16;
  localparam int unsigned DefProgDepth = 32;

  // Processor PC is 13 bits: pc_ext[4:0] concatenated with the 8-bit address byte.
  localparam int unsigned PcWidth = 13;

  typedef enum logic {
    StLoad = 1'b0,
    StRun  = 1'b1
  } bf_state_e;

endpackage

// File: rtl/bf_byte_ram.sv
// Byte-wide RAM: synchronous write, combinational read, optional clear.
// Ports:
//   clk   - clock
//   clr   - synchronous clear of every cell (takes priority over write)
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from raddr)
module bf_byte_ram #(
  parameter int unsigned Depth     = 16,
  parameter int unsigned AddrWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [7:0]           wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [7:0]           rdata
);

  logic [7:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem[i] <= 8'h00;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bf_mem_responder.sv
// Memory responder for a brainf*ck processor: holds program and tape memory,
// accepts a program byte stream while the processor is held in reset, then
// serves the processor's address/read/write bus.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   bus_write/addr/instr     - processor strobes (write, address phase, PC phase)
//   bus_pc_ext               - PC bits 12:8
//   bus_data_in              - address or write data from processor
//   bus_data_out/bus_data_oe - read data and its drive enable
//   load_valid/data/ready    - program load stream
//   run_start                - end of load, release the processor
//   cpu_rst_n                - active-low processor reset, high only in RUN
//   halted                   - processor fetched beyond the loaded program
module bf_mem_responder
  import bf_mem_responder_pkg::*;
#(
  parameter int unsigned TAPE_DEPTH = DefTapeDepth,
  parameter int unsigned PROG_DEPTH = DefProgDepth
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_write,
  input  logic       bus_addr,
  input  logic       bus_instr,
  input  logic [4:0] bus_pc_ext,
  input  logic [7:0] bus_data_in,
  output logic [7:0] bus_data_out,
  output logic       bus_data_oe,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  input  logic       run_start,
  output logic       cpu_rst_n,
  output logic       halted
);

  localparam int unsigned TapeAw = $clog2(TAPE_DEPTH);
  localparam int unsigned ProgAw = $clog2(PROG_DEPTH);
  localparam int unsigned CntW   = ProgAw + 1;

  bf_state_e            state_q, state_d;
  logic [CntW-1:0]      load_cnt_q, load_cnt_d;
  logic [PcWidth-1:0]   prog_ptr_q, prog_ptr_d;
  logic [TapeAw-1:0]    tape_ptr_q, tape_ptr_d;
  logic                 sel_instr_q, sel_instr_d;
  logic                 halted_q, halted_d;
  logic                 cpu_rst_n_q;

  logic                 prog_we, tape_we;
  logic [7:0]           prog_rdata, tape_rdata;
  logic                 fetch_beyond;

  // Fetch is past the loaded program when the full 13-bit PC reaches the load count.
  assign fetch_beyond = prog_ptr_q >= PcWidth'(load_cnt_q);

  bf_byte_ram #(
    .Depth (PROG_DEPTH)
  ) u_prog_ram (
    .clk   (clk),
    .clr   (1'b0),
    .we    (prog_we),
    .waddr (load_cnt_q[ProgAw-1:0]),
    .wdata (load_data),
    .raddr (prog_ptr_q[ProgAw-1:0]),
    .rdata (prog_rdata)
  );

  bf_byte_ram #(
    .Depth (TAPE_DEPTH)
  ) u_tape_ram (
    .clk   (clk),
    .clr   (rst),
    .we    (tape_we),
    .waddr (tape_ptr_q),
    .wdata (bus_data_in),
    .raddr (tape_ptr_q),
    .rdata (tape_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt_q  <= '0;
      prog_ptr_q  <= '0;
      tape_ptr_q  <= '0;
      sel_instr_q <= 1'b1;
      halted_q    <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      prog_ptr_q  <= prog_ptr_d;
      tape_ptr_q  <= tape_ptr_d;
      sel_instr_q <= sel_instr_d;
      halted_q    <= halted_d;
      // Registered from the state so the processor reset never glitches.
      cpu_rst_n_q <= (state_q == StRun);
    end
  end

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    prog_ptr_d   = prog_ptr_q;
    tape_ptr_d   = tape_ptr_q;
    sel_instr_d  = sel_instr_q;
    halted_d     = halted_q;
    prog_we      = 1'b0;
    tape_we      = 1'b0;
    load_ready   = 1'b0;
    bus_data_oe  = 1'b0;
    bus_data_out = 8'h00;

    case (state_q)
      StLoad: begin
        // Count saturates at PROG_DEPTH; no wrap.
        load_ready = (load_cnt_q < CntW'(PROG_DEPTH));
        if (load_valid && load_ready) begin
          prog_we    = 1'b1;
          load_cnt_d = load_cnt_q + CntW'(1);
        end
        if (run_start) begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (bus_write) begin
          if (bus_addr) begin
            if (bus_instr) begin
              prog_ptr_d  = {bus_pc_ext, bus_data_in};
              sel_instr_d = 1'b1;
            end else begin
              tape_ptr_d  = bus_data_in[TapeAw-1:0];
              sel_instr_d = 1'b0;
            end
          end else begin
            tape_we = 1'b1;
          end
        end else begin
          bus_data_oe = 1'b1;
          if (sel_instr_q) begin
            if (fetch_beyond) begin
              halted_d = 1'b1;
            end else begin
              bus_data_out = prog_rdata;
            end
          end else begin
            bus_data_out = tape_rdata;
          end
        end
      end

      default: ;
    endcase
  end

  assign cpu_rst_n = cpu_rst_n_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_bf_mem_responder.sv
// Self-checking bench for bf_mem_responder: a transaction-level model of the
// program/tape memories is compared against the DUT every cycle, plus literal
// expectations at key points of the directed sequence.
module tb_bf_mem_responder;

  localparam int TD = 16;
  localparam int PD = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       bus_write, bus_addr, bus_instr;
  logic [4:0] bus_pc_ext;
  logic [7:0] bus_data_in;
  logic [7:0] bus_data_out;
  logic       bus_data_oe;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       run_start;
  logic       cpu_rst_n;
  logic       halted;

  always #5 clk = ~clk;

  bf_mem_responder #(
    .TAPE_DEPTH (TD),
    .PROG_DEPTH (PD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus_write    (bus_write),
    .bus_addr     (bus_addr),
    .bus_instr    (bus_instr),
    .bus_pc_ext   (bus_pc_ext),
    .bus_data_in  (bus_data_in),
    .bus_data_out (bus_data_out),
    .bus_data_oe  (bus_data_oe),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .run_start    (run_start),
    .cpu_rst_n    (cpu_rst_n),
    .halted       (halted)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: memories as arrays, the rest as plain flags and integers.
  logic [7:0] prog_m [PD];
  logic [7:0] tape_m [TD];
  int         load_cnt_m = 0;
  int         pc_m = 0;
  int         tp_m = 0;
  bit         run_m = 0;
  bit         released_m = 0;
  bit         halted_m = 0;
  bit         sel_m = 1;
  bit         check_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      run_m      <= 0;
      released_m <= 0;
      halted_m   <= 0;
      sel_m      <= 1;
      pc_m       <= 0;
      tp_m       <= 0;
      load_cnt_m <= 0;
      check_en   <= 1;
      for (int i = 0; i < TD; i++) tape_m[i] <= 8'h00;
    end else begin
      // The processor is released one cycle after the run flag is raised.
      released_m <= run_m;
      if (!run_m) begin
        if (load_valid && load_cnt_m < PD) begin
          prog_m[load_cnt_m] <= load_data;
          load_cnt_m         <= load_cnt_m + 1;
        end
        if (run_start) run_m <= 1;
      end else if (bus_write) begin
        if (bus_addr) begin
          if (bus_instr) begin
            pc_m  <= int'({bus_pc_ext, bus_data_in});
            sel_m <= 1;
          end else begin
            tp_m  <= int'(bus_data_in) % TD;
            sel_m <= 0;
          end
        end else begin
          tape_m[tp_m] <= bus_data_in;
        end
      end else if (sel_m && pc_m >= load_cnt_m) begin
        halted_m <= 1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [7:0] exp_do;
    logic       exp_oe;
    if (check_en) begin
      exp_oe = run_m && !bus_write;
      exp_do = 8'h00;
      if (exp_oe) begin
        if (sel_m) exp_do = (pc_m < load_cnt_m) ? prog_m[pc_m] : 8'h00;
        else       exp_do = tape_m[tp_m];
      end
      chk("model_oe",         {7'd0, bus_data_oe}, {7'd0, exp_oe});
      chk("model_data_out",   bus_data_out,        exp_do);
      chk("model_load_ready", {7'd0, load_ready},  {7'd0, (!run_m && load_cnt_m < PD)});
      chk("model_cpu_rst_n",  {7'd0, cpu_rst_n},   {7'd0, released_m});
      chk("model_halted",     {7'd0, halted},      {7'd0, halted_m});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bus(input logic w, input logic a, input logic i,
                           input logic [4:0] pe, input logic [7:0] d);
    bus_write   = w;
    bus_addr    = a;
    bus_instr   = i;
    bus_pc_ext  = pe;
    bus_data_in = d;
  endtask

  // Address phase followed by a read cycle; returns the read data.
  task automatic addr_read(input logic i, input logic [4:0] pe, input logic [7:0] a,
                           output logic [7:0] rd, output logic oe);
    drive_bus(1'b1, 1'b1, i, pe, a);
    step();
    drive_bus(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    #1;
    rd = bus_data_out;
    oe = bus_data_oe;
    step();
  endtask

  logic [7:0] rd;
  logic       oe;
  logic [7:0] first_bytes [3];

  initial begin
    first_bytes[0] = 8'h2B;
    first_bytes[1] = 8'h2B;
    first_bytes[2] = 8'h2E;
    rst = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'h00;
    run_start  = 1'b0;
    drive_bus(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("reset_cpu_rst_n",  {7'd0, cpu_rst_n},  8'd0);
    chk("reset_oe",         {7'd0, bus_data_oe}, 8'd0);
    chk("reset_data_out",   bus_data_out,        8'h00);
    chk("reset_load_ready", {7'd0, load_ready},  8'd1);
    chk("reset_halted",     {7'd0, halted},      8'd0);
    step();

    // Load 3 bytes while junk bus traffic is present (must be ignored).
    for (int k = 0; k < 3; k++) begin
      load_valid = 1'b1;
      load_data  = first_bytes[k];
      drive_bus(1'b1, k[0], 1'b0, 5'd0, 8'hFF);
      #1;
      chk("load3_ready", {7'd0, load_ready}, 8'd1);
      step();
    end
    load_valid = 1'b0;
    drive_bus(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    run_start = 1'b1;
    #1;
    chk("pre_run_cpu_rst_n", {7'd0, cpu_rst_n}, 8'd0);
    step();
    run_start = 1'b0;
    #1;
    chk("run_entry_cpu_rst_n", {7'd0, cpu_rst_n},  8'd0);
    chk("run_load_ready",      {7'd0, load_ready}, 8'd0);
    step();
    chk("run_cpu_rst_n", {7'd0, cpu_rst_n}, 8'd1);

    addr_read(1'b1, 5'd0, 8'h01, rd, oe);
    chk("instr1_data", rd, 8'h2B);
    chk("instr1_oe",   {7'd0, oe}, 8'd1);
    addr_read(1'b1, 5'd0, 8'h02, rd, oe);
    chk("instr2_data", rd, 8'h2E);

    // Tape address 0x13 wraps to cell 3.
    drive_bus(1'b1, 1'b1, 1'b0, 5'd0, 8'h13);
    step();
    drive_bus(1'b1, 1'b0, 1'b0, 5'd0, 8'h55);
    #1;
    chk("write_oe",       {7'd0, bus_data_oe}, 8'd0);
    chk("write_data_out", bus_data_out,        8'h00);
    step();
    drive_bus(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    #1;
    chk("tape_wr_rd", bus_data_out, 8'h55);
    step();
    addr_read(1'b0, 5'd0, 8'h04, rd, oe);
    chk("tape_cell4", rd, 8'h00);
    addr_read(1'b0, 5'd0, 8'h03, rd, oe);
    chk("tape_cell3", rd, 8'h55);

    // Fetch at 256 is beyond the 3-byte program.
    addr_read(1'b1, 5'h01, 8'h00, rd, oe);
    chk("beyond_data", rd, 8'h00);
    chk("beyond_oe",   {7'd0, oe}, 8'd1);
    chk("halted_set",  {7'd0, halted}, 8'd1);
    addr_read(1'b1, 5'd0, 8'h00, rd, oe);
    chk("after_halt_data", rd, 8'h2B);
    chk("halted_held",     {7'd0, halted}, 8'd1);

    // Reset during RUN.
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_run_cpu_rst_n", {7'd0, cpu_rst_n}, 8'd0);
    chk("rst_run_halted",    {7'd0, halted},    8'd0);

    // Load 33 bytes: the 33rd is dropped.
    for (int k = 0; k < 33; k++) begin
      load_valid = 1'b1;
      load_data  = 8'h80 + 8'(k);
      #1;
      chk("load33_ready", {7'd0, load_ready}, (k < 32) ? 8'd1 : 8'd0);
      step();
    end
    load_valid = 1'b0;
    run_start  = 1'b1;
    step();
    run_start  = 1'b0;
    step();
    addr_read(1'b1, 5'd0, 8'h1F, rd, oe);
    chk("prog_last", rd, 8'h9F);
    addr_read(1'b1, 5'd0, 8'h00, rd, oe);
    chk("prog_first", rd, 8'h80);
    addr_read(1'b0, 5'd0, 8'h03, rd, oe);
    chk("tape_cleared", rd, 8'h00);
    addr_read(1'b1, 5'd0, 8'h20, rd, oe);
    chk("byte33_dropped", rd, 8'h00);
    chk("halt_at_32",     {7'd0, halted}, 8'd1);

    // Last byte together with run_start: stored and RUN entered on the same edge.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      load_valid = 1'b1;
      load_data  = 8'h40 + 8'(k);
      run_start  = (k == 31);
      step();
    end
    load_valid = 1'b0;
    run_start  = 1'b0;
    #1;
    chk("same_edge_ready", {7'd0, load_ready}, 8'd0);
    step();
    addr_read(1'b1, 5'd0, 8'h1F, rd, oe);
    chk("same_edge_byte", rd, 8'h5F);
    chk("same_edge_halt", {7'd0, halted}, 8'd0);

    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
